// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//
// Program-counter generator for the instruction fetch stage. It holds the
// current fetch address and chooses the next one from, highest priority first:
// a jump, a taken branch, a redirect saved while the pipeline was stalled, or
// the sequential address. While stalled, pc is frozen and any incoming
// redirect is saved until the stall is released.
//
// Optional feature: define PC_FETCH_COUNT_EN to add the fetch_count output,
// a 16-bit saturating count of pc updates.
//
// Parameters
//   PC_W      PC / address width
//   RESET_PC  pc value loaded on reset
//   PC_INC    sequential increment (word addressing)
//
// Ports
//   clk               in   rising-edge clock
//   rst_n             in   asynchronous active-low reset
//   stall             in   hazard hold, freezes pc
//   imem_ready        in   instruction memory accepted the fetch at pc
//   branch_taken      in   redirect to pc_const
//   pc_const          in   branch target
//   jump              in   redirect to jump_addr
//   jump_addr         in   absolute jump target
//   pc                out  current fetch address (registered)
//   pc_plus_4         out  pc + PC_INC, wrapping at PC_W bits
//   fetch_valid       out  pc is a valid fetch request
//   redirect_pending  out  a redirect is waiting for the stall to release
//   fetch_count       out  (PC_FETCH_COUNT_EN only) saturating update count
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int          PC_W     = 5,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_INC   = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            imem_ready,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] pc_const,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_addr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus_4,
    output logic            fetch_valid,
    output logic            redirect_pending
`ifdef PC_FETCH_COUNT_EN
    ,
    output logic [15:0]     fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] w_pc_seq;
    logic            r_pend_vld;
    logic            w_pend_vld_nxt;
    logic [PC_W-1:0] r_pend_tgt;
    logic [PC_W-1:0] w_pend_tgt_nxt;
    logic            w_pc_load;

    // Addition truncates to PC_W bits, giving the required wrap-around.
    assign w_pc_seq = r_pc + PC_W'(PC_INC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= PC_W'(RESET_PC);
            r_pend_vld <= 1'b0;
            r_pend_tgt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_pend_vld_nxt = r_pend_vld;
        w_pend_tgt_nxt = r_pend_tgt;
        w_pc_load      = 1'b0;
        case (r_state)
            S_BOOT: begin
                // All fetch inputs are ignored for the single boot cycle.
                w_state_nxt = S_RUN;
            end
            S_RUN, S_HOLD: begin
                if (stall) begin
                    w_state_nxt = S_HOLD;
                    // A newer redirect replaces any saved one; jump wins.
                    if (jump) begin
                        w_pend_vld_nxt = 1'b1;
                        w_pend_tgt_nxt = jump_addr;
                    end else if (branch_taken) begin
                        w_pend_vld_nxt = 1'b1;
                        w_pend_tgt_nxt = pc_const;
                    end
                end else begin
                    w_state_nxt    = S_RUN;
                    // The saved redirect is consumed (or superseded) here.
                    w_pend_vld_nxt = 1'b0;
                    if (jump) begin
                        w_pc_nxt  = jump_addr;
                        w_pc_load = 1'b1;
                    end else if (branch_taken) begin
                        w_pc_nxt  = pc_const;
                        w_pc_load = 1'b1;
                    end else if (r_pend_vld) begin
                        w_pc_nxt  = r_pend_tgt;
                        w_pc_load = 1'b1;
                    end else if (imem_ready) begin
                        w_pc_nxt  = w_pc_seq;
                        w_pc_load = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    assign pc               = r_pc;
    assign pc_plus_4        = w_pc_seq;
    assign fetch_valid      = (r_state != S_BOOT);
    assign redirect_pending = r_pend_vld;

`ifdef PC_FETCH_COUNT_EN
    logic [15:0] r_fetch_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
        end else if (w_pc_load && (r_fetch_count != 16'hFFFF)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic       imem_ready;
    logic       branch_taken;
    logic [4:0] pc_const;
    logic       jump;
    logic [4:0] jump_addr;
    logic [4:0] pc;
    logic [4:0] pc_plus_4;
    logic       fetch_valid;
    logic       redirect_pending;
`ifdef PC_FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         id;
        logic [4:0] pc;
        logic [4:0] pp4;
        logic       fv;
        logic       rp;
    } exp_t;

    exp_t exp_q[$];

    pc_fetch_unit #(
        .PC_W    (5),
        .RESET_PC(0),
        .PC_INC  (1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .imem_ready      (imem_ready),
        .branch_taken    (branch_taken),
        .pc_const        (pc_const),
        .jump            (jump),
        .jump_addr       (jump_addr),
        .pc              (pc),
        .pc_plus_4       (pc_plus_4),
        .fetch_valid     (fetch_valid),
        .redirect_pending(redirect_pending)
`ifdef PC_FETCH_COUNT_EN
        ,
        .fetch_count     (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", name, id, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic step(input int id, input logic s, input logic r,
                        input logic b, input logic [4:0] pcc,
                        input logic j, input logic [4:0] ja,
                        input logic [4:0] epc, input logic erp);
        exp_t e;
        stall        = s;
        imem_ready   = r;
        branch_taken = b;
        pc_const     = pcc;
        jump         = j;
        jump_addr    = ja;
        e.id  = id;
        e.pc  = epc;
        e.pp4 = epc + 5'd1;
        e.fv  = 1'b1;
        e.rp  = erp;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares the DUT state one time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", e.id, int'(pc), int'(e.pc));
                chk("pc_plus_4", e.id, int'(pc_plus_4), int'(e.pp4));
                chk("fetch_valid", e.id, int'(fetch_valid), int'(e.fv));
                chk("redirect_pending", e.id, int'(redirect_pending), int'(e.rp));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        stall        = 1'b0;
        imem_ready   = 1'b0;
        branch_taken = 1'b0;
        pc_const     = '0;
        jump         = 1'b0;
        jump_addr    = '0;

        #1;
        chk("reset_pc", 0, int'(pc), 0);
        chk("reset_fetch_valid", 0, int'(fetch_valid), 0);
        chk("reset_redirect_pending", 0, int'(redirect_pending), 0);
`ifdef PC_FETCH_COUNT_EN
        chk("reset_fetch_count", 0, int'(fetch_count), 0);
`endif

        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk("boot_pc", 0, int'(pc), 0);
        chk("boot_fetch_valid", 0, int'(fetch_valid), 0);

        //   id  stall rdy br pcc  jmp ja   -> pc  rp
        step( 1, 0, 1, 0, 5'd0,  0, 5'd0,  5'd0,  0);  // boot edge: ready ignored
        step( 2, 0, 1, 0, 5'd0,  0, 5'd0,  5'd1,  0);
        step( 3, 0, 1, 0, 5'd0,  0, 5'd0,  5'd2,  0);
        step( 4, 0, 1, 0, 5'd0,  0, 5'd0,  5'd3,  0);
        step( 5, 0, 0, 0, 5'd0,  0, 5'd0,  5'd3,  0);  // no ready: hold
        step( 6, 0, 0, 1, 5'd5,  0, 5'd0,  5'd5,  0);
        step( 7, 0, 0, 1, 5'd12, 0, 5'd0,  5'd12, 0);  // branch without ready
        step( 8, 0, 0, 0, 5'd0,  1, 5'd7,  5'd7,  0);
        step( 9, 1, 0, 0, 5'd0,  1, 5'd20, 5'd7,  1);  // jump latched in stall
        step(10, 1, 0, 0, 5'd0,  0, 5'd0,  5'd7,  1);
        step(11, 0, 0, 0, 5'd0,  0, 5'd0,  5'd20, 0);  // pending applied
        step(12, 0, 0, 1, 5'd9,  1, 5'd3,  5'd3,  0);  // jump beats branch
        step(13, 0, 0, 0, 5'd0,  1, 5'd31, 5'd31, 0);
        step(14, 0, 1, 0, 5'd0,  0, 5'd0,  5'd0,  0);  // wrap 31 -> 0
        step(15, 1, 1, 0, 5'd0,  0, 5'd0,  5'd0,  0);  // stall freezes pc
        step(16, 1, 0, 1, 5'd10, 0, 5'd0,  5'd0,  1);
        step(17, 1, 0, 1, 5'd11, 1, 5'd25, 5'd0,  1);  // overwrite, jump wins
        step(18, 0, 1, 0, 5'd0,  0, 5'd0,  5'd25, 0);
        step(19, 1, 0, 1, 5'd14, 0, 5'd0,  5'd25, 1);
        step(20, 0, 0, 0, 5'd0,  1, 5'd2,  5'd2,  0);  // live jump beats pending
        step(21, 0, 1, 0, 5'd0,  0, 5'd0,  5'd3,  0);
        step(22, 1, 0, 0, 5'd0,  1, 5'd9,  5'd3,  1);  // HOLD with pending
`ifdef PC_FETCH_COUNT_EN
        chk("fetch_count", 22, int'(fetch_count), 13);
`endif

        // Asynchronous reset in the middle of a cycle.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_pc", 23, int'(pc), 0);
        chk("async_reset_redirect_pending", 23, int'(redirect_pending), 0);
        chk("async_reset_fetch_valid", 23, int'(fetch_valid), 0);
`ifdef PC_FETCH_COUNT_EN
        chk("async_reset_fetch_count", 23, int'(fetch_count), 0);
`endif
        stall = 1'b0;
        jump  = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        chk("reboot_fetch_valid", 24, int'(fetch_valid), 0);
        step(25, 0, 1, 0, 5'd0, 0, 5'd0, 5'd0, 0);
        step(26, 0, 1, 0, 5'd0, 0, 5'd0, 5'd1, 0);    // discarded redirect stays gone

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            chk("scoreboard_drain", 99, exp_q.size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; clock is clk and reset is rst_n.
REQ-002 The block SHALL have parameter PC_W, default 5: PC and address width.
REQ-003 The block SHALL have parameter RESET_PC, default 0: PC value loaded on reset.
REQ-004 The block SHALL have parameter PC_INC, default 1: sequential increment (word addressing, no x4 scaling).
REQ-005 The block SHALL have port clk  in  1  rising-edge clock.
REQ-006 The block SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 The block SHALL have port stall  in  1  hazard hold; freezes pc.
REQ-008 The block SHALL have port imem_ready  in  1  instruction memory accepted fetch at pc this cycle.
REQ-009 The block SHALL have port branch_taken  in  1  take branch to pc_const.
REQ-010 The block SHALL have port pc_const  in  PC_W  branch target from the offset adder.
REQ-011 The block SHALL have port jump  in  1  take jump to jump_addr.
REQ-012 The block SHALL have port jump_addr  in  PC_W  absolute jump target.
REQ-013 The block SHALL have port pc  out  PC_W  current fetch address (registered).
REQ-014 The block SHALL have port pc_plus_4  out  PC_W  pc + PC_INC (mod 2^PC_W); feeds the offset adder.
REQ-015 The block SHALL have port fetch_valid  out  1  pc is a valid fetch request.
REQ-016 The block SHALL have port redirect_pending  out  1  latched redirect awaiting stall release.

Function
REQ-017 The block SHALL implement states BOOT, RUN, HOLD; BOOT SHALL go to RUN after exactly one cycle, unconditionally.
REQ-018 fetch_valid SHALL be 0 in BOOT and 1 in RUN and HOLD.
REQ-019 State SHALL go RUN->HOLD when stall=1, and HOLD->RUN in the cycle after stall=0 is sampled.
REQ-020 Redirect priority SHALL be: jump > branch_taken > pending redirect > sequential.
REQ-021 With stall=0 in RUN/HOLD, a redirect (jump, branch_taken or pending) SHALL load pc with its target at the next edge, regardless of imem_ready.
REQ-022 With stall=0 and no redirect, pc SHALL advance to pc_plus_4 only when imem_ready=1; otherwise pc holds.
REQ-023 With stall=1, a jump or branch_taken SHALL be latched into the pending register with redirect_pending=1 and pc held.
REQ-024 A new redirect while one is pending SHALL overwrite the pending target, with jump winning.
REQ-025 A pending redirect SHALL load pc on the first edge with stall=0, and redirect_pending SHALL clear on that edge.
REQ-026 In BOOT, jump, branch_taken and imem_ready SHALL be ignored.
REQ-027 pc_plus_4 SHALL be combinational from pc, truncated to PC_W bits; pc SHALL wrap modulo 2^PC_W (e.g. 31+1 -> 0 at PC_W=5).
REQ-028 Redirect targets SHALL be used unmodified, with no alignment or scaling.

Reset
REQ-029 rst_n=0 SHALL immediately force pc=RESET_PC, fetch_valid=0, redirect_pending=0, pending target=0 and state=BOOT, independent of clk.
REQ-030 Assertion of rst_n mid-operation SHALL discard any pending redirect.
REQ-031 Reset release SHALL be sampled on a clk edge, and BOOT SHALL last one full cycle after release.

Configuration
REQ-032 With macro PC_FETCH_COUNT_EN defined, the block SHALL add port fetch_count  out  16, reset to 0, incremented on every edge where pc is updated (sequential or redirect) and saturating at 0xFFFF.
REQ-033 Without PC_FETCH_COUNT_EN, the fetch_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (PC_W=5, RESET_PC=0, PC_INC=1)
REQ-034 Reset release, imem_ready=1, stall=0 -> pc=0 and fetch_valid=0 for one cycle, then fetch_valid=1 and pc 0,1,2,3 on successive edges.
REQ-035 pc=31, imem_ready=1 -> next pc=0, pc_plus_4=1.
REQ-036 pc=5, imem_ready=0, branch_taken=1, pc_const=12 -> next pc=12.
REQ-037 pc=7, stall=1, jump=1 with jump_addr=20 for one cycle -> pc stays 7 and redirect_pending=1; on stall=0 -> next pc=20 and redirect_pending=0.
REQ-038 jump=1 with jump_addr=3, and branch_taken=1 with pc_const=9 in the same cycle -> next pc=3.
REQ-039 rst_n=0 asserted mid-cycle while in HOLD with a redirect pending -> pc=0 and redirect_pending=0 before the next clk edge; with PC_FETCH_COUNT_EN, fetch_count=0.
